// File: rtl/switch_key_input_driver_if.sv
// Peripheral bus bundle shared with the LED display driver: write strobe, word address, write/read data.
// Latency: none of its own; read data is combinational from the slave's register state.
// Backpressure: none; every access completes in a single cycle.
interface switch_key_input_driver_if;
   logic        wb;
   logic [3:2]  addr;
   logic [31:0] wd;
   logic [31:0] rd;

   modport master (output wb, addr, wd, input rd);
   modport slave  (input wb, addr, wd, output rd);
endinterface

// File: rtl/switch_key_input_driver.sv
// Bus-readable switch/key input block: 2-flop sync, tick-sampled debounce, key press events, IRQ.
// Latency: raw input to debounced bit at most 2 + HIST*DEB_CYCLES cycles; IRQ lags its cause by 1 cycle.
// Backpressure: none; register reads are combinational and writes complete in one cycle.
// Optional macro KEY_RELEASE_EVT_EN adds key release events (KEY[23:16]) that also feed the IRQ.
module switch_key_input_driver #(
   parameter int DEB_CYCLES = 250000,
   parameter int HIST       = 3
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   switch_key_input_driver_if.slave   bus,
   input  logic [31:0]                i_switch,
   input  logic [7:0]                 i_key,
   output logic                       o_irq
);

   localparam int             CW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0]  TICK_LAST = CW'(DEB_CYCLES - 1);

   logic [CW-1:0]           r_tick_cnt;
   logic                    w_tick;

   logic [31:0]             r_sw_s1, r_sw_s2;
   logic [7:0]              r_key_s1, r_key_s2;
   logic [7:0]              w_key_sync;

   logic [HIST-1:0][31:0]   r_sw_hist, w_sw_hist_nxt;
   logic [HIST-1:0][7:0]    r_key_hist, w_key_hist_nxt;
   logic [31:0]             w_sw_all1, w_sw_any1;
   logic [7:0]              w_key_all1, w_key_any1;

   logic [31:0]             r_sw_deb, w_sw_deb_nxt;
   logic [7:0]              r_key_deb, w_key_deb_nxt;
   logic [7:0]              w_key_rise;

   logic [7:0]              r_kevt, w_kevt_nxt, w_kevt_clr;
   logic [7:0]              w_evt_pend;
   logic                    w_wr_key, w_wr_ctrl;

   logic [7:0]              r_mask;
   logic                    r_gie;
   logic                    r_irq;

   logic                    w_unused_wd;

`ifdef KEY_RELEASE_EVT_EN
   logic [7:0]              r_krel, w_krel_nxt, w_krel_clr, w_key_fall;
`endif

   assign w_tick     = (r_tick_cnt == TICK_LAST);
   assign w_key_sync = ~r_key_s2;   // keys are active-low on the pins, 1 = pressed from here on
   assign w_wr_key   = bus.wb && (bus.addr == 2'd1);
   assign w_wr_ctrl  = bus.wb && (bus.addr == 2'd2);
   assign w_unused_wd = ^bus.wd[31:16];

   // Two-flop synchronisers for the asynchronous switch and key pins
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_key_s1 <= '0;
         r_key_s2 <= '0;
      end else begin
         r_sw_s1  <= i_switch;
         r_sw_s2  <= r_sw_s1;
         r_key_s1 <= i_key;
         r_key_s2 <= r_key_s1;
      end
   end

   // Free-running sample tick: one pulse every DEB_CYCLES cycles
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + CW'(1);
      end
   end

   // Next history and debounced value; the decision already includes the sample shifted in this tick
   always_comb begin
      w_sw_hist_nxt  = {r_sw_hist[HIST-2:0], r_sw_s2};
      w_key_hist_nxt = {r_key_hist[HIST-2:0], w_key_sync};
      w_sw_all1  = '1;
      w_sw_any1  = '0;
      w_key_all1 = '1;
      w_key_any1 = '0;
      for (int i = 0; i < HIST; i++) begin
         w_sw_all1  = w_sw_all1  & w_sw_hist_nxt[i];
         w_sw_any1  = w_sw_any1  | w_sw_hist_nxt[i];
         w_key_all1 = w_key_all1 & w_key_hist_nxt[i];
         w_key_any1 = w_key_any1 | w_key_hist_nxt[i];
      end
      // all ones -> 1, all zeros -> 0, mixed history -> hold
      w_sw_deb_nxt  = w_tick ? (w_sw_all1  | (r_sw_deb  & w_sw_any1))  : r_sw_deb;
      w_key_deb_nxt = w_tick ? (w_key_all1 | (r_key_deb & w_key_any1)) : r_key_deb;
   end

   // Shift histories and update debounced levels on the sample tick
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sw_hist  <= '0;
         r_key_hist <= '0;
         r_sw_deb   <= '0;
         r_key_deb  <= '0;
      end else if (w_tick) begin
         r_sw_hist  <= w_sw_hist_nxt;
         r_key_hist <= w_key_hist_nxt;
         r_sw_deb   <= w_sw_deb_nxt;
         r_key_deb  <= w_key_deb_nxt;
      end
   end

   // Event set/clear terms: an edge detected this cycle beats a same-cycle write-1-to-clear
   always_comb begin
      w_key_rise = w_key_deb_nxt & ~r_key_deb;
      w_kevt_clr = w_wr_key ? bus.wd[15:8] : 8'h00;
      w_kevt_nxt = (r_kevt & ~w_kevt_clr) | w_key_rise;
`ifdef KEY_RELEASE_EVT_EN
      w_key_fall = ~w_key_deb_nxt & r_key_deb;
      w_krel_clr = w_wr_key ? bus.wd[23:16] : 8'h00;
      w_krel_nxt = (r_krel & ~w_krel_clr) | w_key_fall;
      w_evt_pend = r_kevt | r_krel;
`else
      w_evt_pend = r_kevt;
`endif
   end

   // Key event registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_kevt <= '0;
`ifdef KEY_RELEASE_EVT_EN
         r_krel <= '0;
`endif
      end else begin
         r_kevt <= w_kevt_nxt;
`ifdef KEY_RELEASE_EVT_EN
         r_krel <= w_krel_nxt;
`endif
      end
   end

   // CTRL register: per-key interrupt mask and global enable
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mask <= '0;
         r_gie  <= 1'b0;
      end else if (w_wr_ctrl) begin
         r_mask <= bus.wd[7:0];
         r_gie  <= bus.wd[8];
      end
   end

   // Registered IRQ from pre-edge event/mask state, so it trails its cause by one cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_gie & |(w_evt_pend & r_mask);
      end
   end

   assign o_irq = r_irq;

   // Combinational read mux
   always_comb begin
      bus.rd = 32'h0;
      case (bus.addr)
         2'd0: bus.rd = r_sw_deb;
`ifdef KEY_RELEASE_EVT_EN
         2'd1: bus.rd = {8'h00, r_krel, r_kevt, r_key_deb};
`else
         2'd1: bus.rd = {16'h0000, r_kevt, r_key_deb};
`endif
         2'd2: bus.rd = {23'h0, r_gie, r_mask};
         default: bus.rd = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_switch_key_input_driver.sv
// Bench for switch_key_input_driver: directed scenarios plus random stimulus against a sample-list model.
// Latency: model predicts every cycle's RD and IRQ.
// Backpressure: not applicable.
module tb_switch_key_input_driver;

   localparam int DEB  = 4;
   localparam int HIST = 3;

   logic        clk;
   logic        rst;
   logic [31:0] sw;
   logic [7:0]  key;
   logic        irq;

   switch_key_input_driver_if bus();

   switch_key_input_driver #(.DEB_CYCLES(DEB), .HIST(HIST)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .bus      (bus),
      .i_switch (sw),
      .i_key    (key),
      .o_irq    (irq)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   int          m_cnt;                  // edges since reset release
   logic [31:0] m_sw_p1, m_sw_p2;       // raw pins one and two edges back
   logic [7:0]  m_key_p1, m_key_p2;
   logic [31:0] m_sw_q[$];              // last HIST tick samples
   logic [7:0]  m_key_q[$];
   logic [31:0] m_sw_deb;
   logic [7:0]  m_key_deb, m_kevt, m_krel, m_mask;
   logic        m_gie, m_irq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_sw_p1 = '0; m_sw_p2 = '0; m_key_p1 = '0; m_key_p2 = '0;
      m_sw_q.delete(); m_key_q.delete();
      for (int i = 0; i < HIST; i++) begin
         m_sw_q.push_back('0);
         m_key_q.push_back('0);
      end
      m_sw_deb = '0; m_key_deb = '0; m_kevt = '0; m_krel = '0;
      m_mask = '0; m_gie = 1'b0; m_irq = 1'b0;
   endtask

   function automatic logic [31:0] m_rd(input logic [1:0] a);
      case (a)
         2'd0: return m_sw_deb;
`ifdef KEY_RELEASE_EVT_EN
         2'd1: return {8'h00, m_krel, m_kevt, m_key_deb};
`else
         2'd1: return {16'h0, m_kevt, m_key_deb};
`endif
         2'd2: return {23'h0, m_gie, m_mask};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge(input logic wb, input logic [1:0] a, input logic [31:0] wd,
                             input logic [31:0] sw_raw, input logic [7:0] key_raw);
      logic [31:0] s_all, s_any;
      logic [7:0]  k_all, k_any, k_old, pend;
      logic        irq_n;
`ifdef KEY_RELEASE_EVT_EN
      pend = m_kevt | m_krel;
`else
      pend = m_kevt;
`endif
      irq_n = m_gie & |(pend & m_mask);
      k_old = m_key_deb;
      if (m_cnt % DEB == DEB - 1) begin
         m_sw_q.push_back(m_sw_p2);
         m_key_q.push_back(~m_key_p2);
         if (m_sw_q.size() > HIST) void'(m_sw_q.pop_front());
         if (m_key_q.size() > HIST) void'(m_key_q.pop_front());
         s_all = '1; s_any = '0; k_all = '1; k_any = '0;
         foreach (m_sw_q[i]) begin
            s_all &= m_sw_q[i]; s_any |= m_sw_q[i];
         end
         foreach (m_key_q[i]) begin
            k_all &= m_key_q[i]; k_any |= m_key_q[i];
         end
         m_sw_deb  = s_all | (m_sw_deb & s_any);
         m_key_deb = k_all | (m_key_deb & k_any);
      end
      if (wb && a == 2'd1) begin
         m_kevt &= ~wd[15:8];
         m_krel &= ~wd[23:16];
      end
      m_kevt |= m_key_deb & ~k_old;
`ifdef KEY_RELEASE_EVT_EN
      m_krel |= ~m_key_deb & k_old;
`else
      m_krel = '0;
`endif
      if (wb && a == 2'd2) begin
         m_mask = wd[7:0];
         m_gie  = wd[8];
      end
      m_irq = irq_n;
      m_sw_p2 = m_sw_p1;  m_sw_p1 = sw_raw;
      m_key_p2 = m_key_p1; m_key_p1 = key_raw;
      m_cnt++;
   endtask

   // one clock: advance model with pre-edge inputs, then compare away from the edge
   task automatic cyc();
      @(posedge clk);
      model_edge(bus.wb, bus.addr, bus.wd, sw, key);
      #1;
      check("irq", {31'b0, irq}, {31'b0, m_irq});
      check("rd", bus.rd, m_rd(bus.addr));
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.wb = 1'b1; bus.addr = a; bus.wd = d;
      cyc();
      bus.wb = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      bus.addr = a;
      #1;
      check(tag, bus.rd, exp);
   endtask

   initial begin
      int first_on;
      bit fired;
      rst = 1'b1; sw = 32'hFFFF_FFFF; key = 8'hFF;
      bus.wb = 1'b0; bus.addr = 2'd0; bus.wd = '0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      for (int a = 0; a < 4; a++) rd_chk("rst_rd", 2'(a), 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      rst = 1'b0;
      model_reset();

      // switch debounce latency after reset
      bus.addr = 2'd0;
      first_on = -1;
      for (int n = 1; n <= 20; n++) begin
         cyc();
         if (first_on < 0 && bus.rd == 32'hFFFF_FFFF) first_on = n;
      end
      check("sw_latency_window", {31'b0, (first_on >= 2 + (HIST-1)*DEB + 1) && (first_on <= 2 + HIST*DEB)}, 32'h1);

      // key press, IRQ enable, W1C
      key = 8'hFE;
      repeat (20) cyc();
      rd_chk("key_press", 2'd1, 32'h0000_0101);
      wr(2'd2, 32'h101);
      check("irq_write_edge", {31'b0, irq}, 32'h0);
      cyc();
      check("irq_one_later", {31'b0, irq}, 32'h1);
      wr(2'd1, 32'h100);
      rd_chk("key_w1c", 2'd1, 32'h0000_0001);
      cyc();
      check("irq_cleared", {31'b0, irq}, 32'h0);

      // bounce on key 3, phased so every tick sample lands on the released level
      key = 8'hFF;
      repeat (20) cyc();
      wr(2'd1, 32'h00FF_FF00);
      bus.addr = 2'd1;
      for (int i = 0; i < 20; i++) begin
         key = (((m_cnt + 1) % DEB) < 2) ? 8'hF7 : 8'hFF;
         cyc();
         check("bounce", bus.rd & 32'h0008_0808, 32'h0);
      end
      key = 8'hFF;
      for (int i = 0; i < 16; i++) begin
         cyc();
         check("bounce_after", bus.rd & 32'h0008_0808, 32'h0);
      end

      // set beats W1C on the same edge
      key = 8'hFD;
      bus.wb = 1'b1; bus.addr = 2'd1; bus.wd = 32'h0000_0200;
      fired = 1'b0;
      for (int i = 0; i < 40 && !fired; i++) begin
         cyc();
         fired = m_key_deb[1];
      end
      check("set_fired", {31'b0, fired}, 32'h1);
      check("set_wins", (bus.rd >> 9) & 32'h1, 32'h1);
      bus.wb = 1'b0;

      // masking
      key = 8'hFF;
      repeat (20) cyc();
      wr(2'd1, 32'h00FF_FF00);
      key = 8'hFB;
      repeat (20) cyc();
      rd_chk("kevt_04", 2'd1, 32'h0000_0404);
      wr(2'd2, 32'h102); cyc();
      check("mask_off", {31'b0, irq}, 32'h0);
      wr(2'd2, 32'h104); cyc();
      check("mask_on", {31'b0, irq}, 32'h1);
      wr(2'd2, 32'h004); cyc();
      check("gie_off", {31'b0, irq}, 32'h0);

      // reserved and read-only writes
      wr(2'd0, 32'hFFFF_FFFF);
      wr(2'd0, 32'h0);
      rd_chk("switch_ro", 2'd0, 32'hFFFF_FFFF);
      wr(2'd3, 32'hFFFF_FFFF);
      rd_chk("reserved", 2'd3, 32'h0);
      wr(2'd2, 32'hFFFF_FFFF);
      rd_chk("ctrl_rw", 2'd2, 32'h0000_01FF);

      // press then release key 0: release event field
      key = 8'hFE;
      repeat (20) cyc();
      wr(2'd1, 32'h00FF_FF00);
      key = 8'hFF;
      repeat (20) cyc();
      bus.addr = 2'd1;
      #1;
`ifdef KEY_RELEASE_EVT_EN
      check("krel", (bus.rd >> 16) & 32'hFF, 32'h01);
`else
      check("krel", (bus.rd >> 16) & 32'hFF, 32'h00);
`endif

      // reset in mid-operation with a key and switches still active
      key = 8'hFE; sw = 32'h1234_5678;
      repeat (20) cyc();
      #5 rst = 1'b1;
      for (int a = 0; a < 4; a++) rd_chk("midrst_rd", 2'(a), 32'h0);
      check("midrst_irq", {31'b0, irq}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      repeat (20) cyc();
      rd_chk("midrst_key", 2'd1, 32'h0000_0101);
      rd_chk("midrst_sw", 2'd0, 32'h1234_5678);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) sw = $urandom;
         if ($urandom_range(0, 9) == 0) key = 8'($urandom);
         if ($urandom_range(0, 7) == 0) key = key ^ 8'(1 << $urandom_range(0, 7));
         bus.wb   = ($urandom_range(0, 3) == 0);
         bus.addr = 2'($urandom);
         bus.wd   = $urandom;
         cyc();
      end
      bus.wb = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
